// File: rtl/pwm_pkg.sv
// Shared PWM definitions: channel bit positions and the duty-count width helper.
package pwm_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_R   = 2;
  localparam int unsigned CH_G   = 1;
  localparam int unsigned CH_B   = 0;

  // Width able to hold 0..interval inclusive (always-high input reaches interval).
  function automatic int unsigned duty_width(input int unsigned interval);
    return $clog2(interval + 1);
  endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// One PWM channel: synchronizer, rising-edge detector, high-time and edge counters,
// and the per-window duty/edge_err result registers.
module pwm_capture_channel
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DW          = duty_width(1200)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  input  logic          window_end,
  output logic [DW-1:0] duty,
  output logic          edge_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic [DW-1:0]          hi_cnt;
  logic [1:0]             edge_cnt;
  logic                   s_c;
  logic                   rising_c;
  logic [2:0]             edge_sum_c;

  assign s_c        = sync_q[SYNC_STAGES-1];
  assign rising_c   = s_c & ~s_prev;
  assign edge_sum_c = {1'b0, edge_cnt} + {2'b00, rising_c};

  // Input synchronizer and previous-sample flop; s_prev resets low so a
  // line already high at release registers as a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_prev <= s_c;
    end
  end

  // Window accumulation; the final cycle's sample is folded into the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt   <= '0;
      edge_cnt <= 2'd0;
      duty     <= '0;
      edge_err <= 1'b0;
    end else if (window_end) begin
      duty     <= hi_cnt + DW'(s_c);
      edge_err <= (edge_sum_c > 3'd1);
      hi_cnt   <= '0;
      edge_cnt <= 2'd0;
    end else begin
      hi_cnt <= hi_cnt + DW'(s_c);
      if (rising_c && (edge_cnt != 2'd3)) begin
        edge_cnt <= edge_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures the high-time of three PWM lines over free-running windows of
// PWM_INTERVAL clocks and flags windows with more than one rising edge.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned SYNC_STAGES  = 2,
  localparam int unsigned DW          = duty_width(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    pwm_in,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          sample_valid,
  output logic [2:0]    edge_err
);

  logic [DW-1:0] win;
  logic          window_end_c;
  logic [DW-1:0] duty_ch [NUM_CH];

  assign window_end_c = (win == DW'(PWM_INTERVAL - 1));

  // Shared window counter; phase is independent of the measured sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win          <= '0;
      sample_valid <= 1'b0;
    end else begin
      win          <= window_end_c ? '0 : win + DW'(1);
      sample_valid <= window_end_c;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pwm_capture_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DW          (DW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in[ch]),
      .window_end (window_end_c),
      .duty       (duty_ch[ch]),
      .edge_err   (edge_err[ch])
    );
  end

  assign duty_r = duty_ch[CH_R];
  assign duty_g = duty_ch[CH_G];
  assign duty_b = duty_ch[CH_B];

endmodule

// File: doc/pwm_duty_capture.md
# pwm_duty_capture

- Receive-side counterpart of the RGB PWM fade driver.
- Samples the three PWM lines (red, green, blue) over fixed windows of `PWM_INTERVAL` clocks and reports each channel's measured high-time as a duty count.
- Also flags windows containing more than one rising edge.
- Sits in self-check and loopback builds, where the driver outputs are wired back in, and in benches that need a numeric duty value instead of a waveform.

## Interface
Parameters:
- `PWM_INTERVAL`, default 1200 — window length in clocks; equals the driver's PWM period.
- `SYNC_STAGES`, default 2 — input synchronizer depth, legal values 1–3.

Ports (`DW` = `$clog2(PWM_INTERVAL+1)`):
- `clk` input 1 — single clock; all logic is on its rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `pwm_in` input 3 — [2] red, [1] green, [0] blue.
- `duty_r` output DW — red high-count from the last completed window.
- `duty_g` output DW — green high-count from the last completed window.
- `duty_b` output DW — blue high-count from the last completed window.
- `sample_valid` output 1 — one-cycle pulse when the duty outputs update.
- `edge_err` output 3 — per channel, same bit order as `pwm_in`: more than one rising edge seen in the last window.

## Operation
- **Input path:** each `pwm_in` bit passes through `SYNC_STAGES` flops, giving `s[ch]`. A further flop holds `s_prev[ch]` for edge detection. A rising edge means `s=1` and `s_prev=0`.
- **Window counter `win`:**
  - Counts 0 … `PWM_INTERVAL-1`, then wraps to 0.
  - Free-running and phase-independent of the source.
  - A constant-duty source therefore measures correctly at any phase.
- **Per-channel counters:**
  - `hi_cnt` (DW bits) increments on each cycle where `s=1`.
  - `edge_cnt` (2 bits) increments on each rising edge and saturates at 3.
- **At the last window cycle (`win == PWM_INTERVAL-1`), on the same edge:**
  - `duty_x <= hi_cnt + s`.
  - `edge_err[ch] <= (edge_cnt + rising_now) > 1`.
  - `hi_cnt` and `edge_cnt` clear to 0.
  - `sample_valid <= 1`.
- **All other cycles:** `sample_valid <= 0`; `duty_*` and `edge_err` hold.
- **Width:** `duty` reaches `PWM_INTERVAL` when the input is always high, so DW must represent `PWM_INTERVAL` inclusive. `hi_cnt` cannot overflow.
- **Reset (asynchronous):**
  - Sync flops, `s_prev`, `win`, all counters and all outputs go to 0.
  - An input already high at reset release counts as a rising edge in the first window.
- **Reset mid-window:** the partial window is discarded; no `sample_valid`.
- **Boundary behaviour:**
  - Constant-low input → duty 0, `edge_err` 0.
  - Constant-high input → duty `PWM_INTERVAL`, `edge_err` 0 after the first window.
  - Pulse straddling the window boundary → split across windows; each window's duty reflects only its own cycles.

## Timing
- Pin to counter: `SYNC_STAGES` cycles.
- First window starts at `win=0` on the first clock edge after `rst` falls.
- First `sample_valid` is high during clock cycle `PWM_INTERVAL` after release (cycles numbered from 0).
- `sample_valid` then repeats every `PWM_INTERVAL` cycles, exactly one cycle wide.
- `duty_*` and `edge_err` change only on the edge that raises `sample_valid`, and are stable for the whole next window.
- Duty reflects input samples delayed by `SYNC_STAGES`. Steady-state duty is exact; the first window after reset undercounts by at most `SYNC_STAGES`.

## Structure
- `pwm_pkg`:
  - `localparam` function `duty_width(interval)`.
  - Channel index constants `CH_R=2`, `CH_G=1`, `CH_B=0`.
  - Shared with the fade driver.
- Sub-module `pwm_capture_channel`, instantiated 3×:
  - Contains the synchronizer, edge detector, `hi_cnt`/`edge_cnt`, and the `duty` and `edge_err` registers.
  - Input `window_end` comes from the shared `win` counter in the top module.
- Top module holds `win`, generates `sample_valid`, and maps channels to ports.

## Test plan
Bench uses `PWM_INTERVAL=10`, `SYNC_STAGES=2`, a 12 MHz-equivalent clock, and `pwm_in` driven off the falling edge.
- **Reset and hold low:** hold `rst` 5 cycles, then all inputs low → every output 0 during reset. After release, `sample_valid` pulses at cycles 10, 20, 30 with all duties 0 and `edge_err` 000.
- **Periodic PWM:** R=3/10, G=7/10, B=10/10, sources started at arbitrary phase → from the second window on, `duty_r=3`, `duty_g=7`, `duty_b=10`, `edge_err=000`.
- **Glitchy input:** G = two 1-cycle pulses per 10 cycles → `duty_g=2`, `edge_err[1]=1`. After returning to a single pulse, the next window shows `edge_err[1]=0`.
- **Duty step:** R steps from 2/10 to 8/10 → `duty_r` goes 2 → a transitional value between 2 and 8 → 8. It changes only on `sample_valid` edges.
- **Reset mid-window:** assert `rst` at `win=5` with `duty_r=3` → `duty_r=0` immediately (asynchronous) and `sample_valid` stays 0. After release, the first pulse comes 10 cycles later.
- **Default parameter:** `PWM_INTERVAL=1200`, R driven at 600/1200 → `duty_r=600`, DW=11 bits. Constant high → `duty_r=1200`.
